// File: rtl/ser_pkg.sv
// Shared types and helpers for the frame serializer.
package ser_pkg;

    // Frame phases. The state names the kind of bit currently on serial_out.
    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_PARITY
    } ser_state_t;

    // Widest data word the parity helper can accept.
    localparam int unsigned PARITY_MAX_W = 64;

    // Even parity is the XOR of the data bits. Odd parity inverts it.
    function automatic logic parity_f(input logic [PARITY_MAX_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry valid/ready holding register that sits between the sample input and the framer.
module ser_hold_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             full_q;
    logic [WIDTH-1:0] data_q;

    assign in_ready  = !full_q;
    assign out_valid = full_q;
    assign out_data  = data_q;

    // Push wins over pop, so a word taken on the edge the old one leaves stays held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (flush) begin
            full_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            full_q <= 1'b1;
            data_q <= in_data;
        end else if (out_valid && out_ready) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/frame_serializer.sv
// Parallel-to-serial framer: optional sync preamble, data bits, optional parity bit.
// One frame bit is emitted per bit_en strobe, and frames run back to back when a word is waiting.
module frame_serializer
    import ser_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned SYNC_LEN   = 4,
    parameter logic [31:0] SYNC_WORD  = 32'hA,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             bit_en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy
);

    localparam int unsigned CNT_MAX  = (WIDTH > SYNC_LEN) ? WIDTH : SYNC_LEN;
    localparam int unsigned CW       = $clog2(CNT_MAX + 1);
    // Clamped so the SYNC_LEN == 0 build never forms a negative index.
    localparam int unsigned SYNC_TOP = (SYNC_LEN > 0) ? SYNC_LEN - 1 : 0;

    ser_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic             serial_q, serial_d;
    logic             bit_valid_q, bit_valid_d;
    logic             frame_start_q, frame_start_d;

    logic             hold_valid;
    logic [WIDTH-1:0] hold_data;
    logic             load;
    logic             frame_end;
    logic [CW-1:0]    sync_idx;

    logic             shift_first, hold_first;
    logic [WIDTH-1:0] shift_next, hold_next;

    ser_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (clk),
        .reset    (reset),
        .flush    (!enable),
        .in_valid (in_valid && enable),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(hold_valid),
        .out_ready(load),
        .out_data (hold_data)
    );

    // Bit to send next and the word left after sending it, for both the shifter and the hold.
    always_comb begin
        shift_first = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
        hold_first  = MSB_FIRST ? hold_data[WIDTH-1] : hold_data[0];
        shift_next  = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
        hold_next   = MSB_FIRST ? {hold_data[WIDTH-2:0], 1'b0} : {1'b0, hold_data[WIDTH-1:1]};
        sync_idx    = cnt_q - CW'(1);
    end

    // Next-state and next-output logic. Everything advances only on bit_en, except frame_start.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        par_d         = par_q;
        serial_d      = serial_q;
        bit_valid_d   = bit_valid_q;
        frame_start_d = 1'b0;
        load          = 1'b0;
        frame_end     = 1'b0;

        if (!enable) begin
            state_d     = S_IDLE;
            serial_d    = IDLE_LEVEL;
            bit_valid_d = 1'b0;
        end else if (bit_en) begin
            case (state_q)
                S_IDLE: frame_end = 1'b1;
                S_SYNC: begin
                    if (cnt_q != '0) begin
                        cnt_d    = sync_idx;
                        serial_d = SYNC_WORD[sync_idx];
                    end else begin
                        state_d  = S_DATA;
                        cnt_d    = CW'(WIDTH - 1);
                        serial_d = shift_first;
                        shift_d  = shift_next;
                    end
                end
                S_DATA: begin
                    if (cnt_q != '0) begin
                        cnt_d    = cnt_q - CW'(1);
                        serial_d = shift_first;
                        shift_d  = shift_next;
                    end else if (PARITY_EN) begin
                        state_d  = S_PARITY;
                        serial_d = par_q;
                    end else begin
                        frame_end = 1'b1;
                    end
                end
                S_PARITY: frame_end = 1'b1;
                default:  frame_end = 1'b1;
            endcase

            // Leaving the last bit (or idling): start the next frame at once if a word waits.
            if (frame_end) begin
                if (hold_valid) begin
                    load          = 1'b1;
                    frame_start_d = 1'b1;
                    bit_valid_d   = 1'b1;
                    // Parity from the intact word, before any shifting.
                    par_d         = parity_f(PARITY_MAX_W'(hold_data), PARITY_ODD);
                    if (SYNC_LEN > 0) begin
                        state_d  = S_SYNC;
                        cnt_d    = CW'(SYNC_TOP);
                        serial_d = SYNC_WORD[SYNC_TOP];
                        shift_d  = hold_data;
                    end else begin
                        state_d  = S_DATA;
                        cnt_d    = CW'(WIDTH - 1);
                        serial_d = hold_first;
                        shift_d  = hold_next;
                    end
                end else begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    serial_d    = IDLE_LEVEL;
                    bit_valid_d = 1'b0;
                end
            end
        end
    end

    // State, shifter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            par_q         <= 1'b0;
            serial_q      <= IDLE_LEVEL;
            bit_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            serial_q      <= serial_d;
            bit_valid_q   <= bit_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign serial_out  = serial_q;
    assign bit_valid   = bit_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q != S_IDLE) || hold_valid;

endmodule

// File: tb/tb_frame_serializer.sv
// Scoreboard bench for frame_serializer: default build (A) and LSB-first/no-sync/odd build (B).
module tb_frame_serializer;

    typedef struct packed {
        logic val;
        logic fs;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic bit_en;

    logic       va, rdy_a, so_a, bv_a, fs_a, busy_a;
    logic [7:0] da;
    logic       vb, rdy_b, so_b, bv_b, fs_b, busy_b;
    logic [7:0] db;

    exp_t qa[$];
    exp_t qb[$];

    int checks = 0;
    int errors = 0;
    int be_div = 1;
    int be_cnt = 0;

    logic be_a = 1'b0;
    logic be_b = 1'b0;
    logic last_a = 1'b0;
    logic last_b = 1'b0;

    always #5 clk = ~clk;

    frame_serializer u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bit_en     (bit_en),
        .in_data    (da),
        .in_valid   (va),
        .in_ready   (rdy_a),
        .serial_out (so_a),
        .bit_valid  (bv_a),
        .frame_start(fs_a),
        .busy       (busy_a)
    );

    frame_serializer #(
        .WIDTH     (8),
        .MSB_FIRST (1'b0),
        .SYNC_LEN  (0),
        .SYNC_WORD (32'h0),
        .PARITY_EN (1'b1),
        .PARITY_ODD(1'b1),
        .IDLE_LEVEL(1'b0)
    ) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bit_en     (bit_en),
        .in_data    (db),
        .in_valid   (vb),
        .in_ready   (rdy_b),
        .serial_out (so_b),
        .bit_valid  (bv_b),
        .frame_start(fs_b),
        .busy       (busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Push the first n emitted bits of a 13-bit default frame, leftmost bit first.
    task automatic push_a(input logic [12:0] f, input int n);
        for (int i = 0; i < n; i++) qa.push_back('{val: f[12-i], fs: (i == 0)});
    endtask

    task automatic push_b(input logic [8:0] f);
        for (int i = 0; i < 9; i++) qb.push_back('{val: f[8-i], fs: (i == 0)});
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input bit sel, input logic [7:0] w);
        int n = 0;
        if (sel) begin vb = 1'b1; db = w; end
        else begin va = 1'b1; da = w; end
        while (!(sel ? rdy_b : rdy_a) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("send_timeout", 32'(n), 32'(0));
        @(negedge clk);
        va = 1'b0;
        vb = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) check("drain_timeout", 32'(qa.size() + qb.size()), 32'(0));
        @(negedge clk);
    endtask

    task automatic wait_qa(input int sz);
        int n = 0;
        while (qa.size() != sz && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) check("wait_qa_timeout", 32'(qa.size()), 32'(sz));
    endtask

    // Bit-rate strobe: high one cycle in every be_div.
    initial begin
        bit_en = 1'b1;
        forever begin
            @(negedge clk);
            be_cnt++;
            bit_en = ((be_cnt % be_div) == 0);
        end
    end

    // Remember whether each edge was a bit-advance edge for the monitors.
    always @(posedge clk) begin
        be_a <= bit_en && enable && !reset;
        be_b <= bit_en && enable && !reset;
    end

    // Monitor A: compare each new bit with the scoreboard; between strobes outputs must hold.
    always @(negedge clk) begin
        if (!reset) begin
            if (be_a) begin
                if (bv_a) begin
                    if (qa.size() == 0) begin
                        check("unexpected_bit_a", 32'(so_a), 32'hDEAD);
                    end else begin
                        exp_t e;
                        e = qa.pop_front();
                        check("serial_a", 32'(so_a), 32'(e.val));
                        check("frame_start_a", 32'(fs_a), 32'(e.fs));
                    end
                    last_a = so_a;
                end
            end else begin
                check("fs_pulse_a", 32'(fs_a), 32'(0));
                if (bv_a) check("bit_hold_a", 32'(so_a), 32'(last_a));
            end
        end
    end

    // Monitor B.
    always @(negedge clk) begin
        if (!reset) begin
            if (be_b) begin
                if (bv_b) begin
                    if (qb.size() == 0) begin
                        check("unexpected_bit_b", 32'(so_b), 32'hDEAD);
                    end else begin
                        exp_t e;
                        e = qb.pop_front();
                        check("serial_b", 32'(so_b), 32'(e.val));
                        check("frame_start_b", 32'(fs_b), 32'(e.fs));
                    end
                    last_b = so_b;
                end
            end else begin
                check("fs_pulse_b", 32'(fs_b), 32'(0));
                if (bv_b) check("bit_hold_b", 32'(so_b), 32'(last_b));
            end
        end
    end

    initial begin
        int run;
        int fs_pos0;
        int fs_pos1;
        reset  = 1'b1;
        enable = 1'b1;
        va = 1'b0; da = '0;
        vb = 1'b0; db = '0;

        // Reset values while reset is held.
        #2;
        check("rst_serial", 32'(so_a), 32'(0));
        check("rst_bit_valid", 32'(bv_a), 32'(0));
        check("rst_frame_start", 32'(fs_a), 32'(0));
        check("rst_busy", 32'(busy_a), 32'(0));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(rdy_a), 32'(1));

        // 1: A5 -> 1010 | 10100101 | 0
        push_a(13'b1010_10100101_0, 13);
        send(1'b0, 8'hA5);
        wait_empty();
        repeat (2) @(negedge clk);
        check("idle_bit_valid", 32'(bv_a), 32'(0));
        check("idle_serial", 32'(so_a), 32'(0));
        check("idle_busy", 32'(busy_a), 32'(0));

        // 2: 3C then FF back to back, both even parity 0.
        push_a(13'b1010_00111100_0, 13);
        push_a(13'b1010_11111111_0, 13);
        run = 0;
        fs_pos0 = -1;
        fs_pos1 = -1;
        fork
            begin
                send(1'b0, 8'h3C);
                send(1'b0, 8'hFF);
            end
            begin
                int n = 0;
                while (!bv_a && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                while (bv_a && run < 60) begin
                    if (fs_a) begin
                        if (fs_pos0 < 0) fs_pos0 = run;
                        else fs_pos1 = run;
                    end
                    run++;
                    @(negedge clk);
                end
            end
        join
        check("contiguous_bits", 32'(run), 32'(26));
        check("frame_spacing", 32'(fs_pos1 - fs_pos0), 32'(13));
        wait_empty();

        // 3: slow strobe; second word waits in hold until the first frame ends.
        be_div = 4;
        push_a(13'b1010_10100101_0, 13);
        push_a(13'b1010_00001111_0, 13);
        send(1'b0, 8'hA5);
        send(1'b0, 8'h0F);
        check("held_in_ready", 32'(rdy_a), 32'(0));
        check("held_busy", 32'(busy_a), 32'(1));
        repeat (6) @(negedge clk);
        check("held_in_ready_later", 32'(rdy_a), 32'(0));
        wait_empty();
        be_div = 1;
        repeat (8) @(negedge clk);

        // 4: abort during data bit 5, then a clean 81 frame.
        push_a(13'b1010_10100101_0, 10);
        send(1'b0, 8'hA5);
        wait_qa(1);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("abort_serial", 32'(so_a), 32'(0));
        check("abort_bit_valid", 32'(bv_a), 32'(0));
        check("abort_in_ready", 32'(rdy_a), 32'(1));
        check("abort_busy", 32'(busy_a), 32'(0));
        enable = 1'b1;
        push_a(13'b1010_10000001_0, 13);
        send(1'b0, 8'h81);
        wait_empty();
        repeat (3) @(negedge clk);

        // 5: reset during the preamble, then a clean 5B frame (odd popcount -> parity 1).
        push_a(13'b1010_00000000_0, 2);
        send(1'b0, 8'hC3);
        wait_qa(1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("async_serial", 32'(so_a), 32'(0));
        check("async_bit_valid", 32'(bv_a), 32'(0));
        check("async_frame_start", 32'(fs_a), 32'(0));
        check("async_busy", 32'(busy_a), 32'(0));
        check("async_in_ready", 32'(rdy_a), 32'(1));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_bit_valid", 32'(bv_a), 32'(0));
        push_a(13'b1010_01011011_1, 13);
        send(1'b0, 8'h5B);
        wait_empty();
        repeat (3) @(negedge clk);

        // 6: LSB first, no preamble, odd parity.
        push_b(9'b1_0000000_0);
        send(1'b1, 8'h01);
        push_b(9'b0110_0000_1);
        send(1'b1, 8'h06);
        wait_empty();
        repeat (3) @(negedge clk);
        check("idle_bit_valid_b", 32'(bv_b), 32'(0));
        check("queue_a_drained", 32'(qa.size()), 32'(0));
        check("queue_b_drained", 32'(qb.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
